// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants and the arbiter state encoding.
package alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_ADDU = 4'd2;
  localparam logic [3:0] ALU_SUBU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i  - request vector
//   ptr_i  - highest-priority index; search runs upward from here with wrap
//   gnt_o  - one-hot grant (zero when no request)
//   id_o   - encoded winner index
//   any_o  - at least one request present
module rr_arbiter #(
  parameter int N   = 2,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] id_o,
  output logic           any_o
);
  int idx;

  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    any_o = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational 32-bit ALU among
// NUM_REQ requesters. One operation in flight: IDLE -> EXEC -> RESP.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   req_valid/req_ready        - per-requester request handshake (grant one-hot)
//   req_ctrl/req_op1/req_op2   - flattened per-requester opcode and operands
//   alu_ctrl/alu_op1/alu_op2   - registered ALU inputs (hold last operation)
//   alu_result/alu_overflow    - ALU combinational outputs
//   rsp_valid/rsp_ready        - response handshake; only rsp_ready[rsp_id] counts
//   rsp_id/rsp_result/rsp_overflow - response payload
//   busy                       - not IDLE
// Optional (ALU_ARB_OVF_STAT_EN): ovf_clr, ovf_sticky, ovf_count overflow stats.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_ctrl,
  input  logic [32*NUM_REQ-1:0]   req_op1,
  input  logic [32*NUM_REQ-1:0]   req_op2,
  output logic [3:0]              alu_ctrl,
  output logic [31:0]             alu_op1,
  output logic [31:0]             alu_op2,
  input  logic [31:0]             alu_result,
  input  logic                    alu_overflow,
  output logic                    rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_result,
  output logic                    rsp_overflow,
  output logic                    busy
`ifdef ALU_ARB_OVF_STAT_EN
  ,
  input  logic                    ovf_clr,
  output logic                    ovf_sticky,
  output logic [7:0]              ovf_count
`endif
);
  localparam int NPAD = 1 << ID_W;

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [3:0]          alu_ctrl_q, alu_ctrl_d;
  logic [31:0]         alu_op1_q, alu_op1_d, alu_op2_q, alu_op2_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [31:0]         rsp_res_q, rsp_res_d;
  logic                rsp_ovf_q, rsp_ovf_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     win_id;
  logic                win_any;
  // Padded so rsp_id can index it directly for any NUM_REQ/ID_W combination.
  logic [NPAD-1:0]     rsp_ready_pad;

  assign rsp_ready_pad = NPAD'(rsp_ready);

  rr_arbiter #(.N(NUM_REQ), .IDW(ID_W)) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .id_o  (win_id),
    .any_o (win_any)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    alu_ctrl_d  = alu_ctrl_q;
    alu_op1_d   = alu_op1_q;
    alu_op2_d   = alu_op2_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_res_d   = rsp_res_q;
    rsp_ovf_d   = rsp_ovf_q;
    req_ready   = '0;
    unique case (state_q)
      IDLE: begin
        // Grant goes only to a valid requester, so a grant is a handshake.
        req_ready = gnt;
        if (win_any) begin
          alu_ctrl_d = req_ctrl[4*int'(win_id) +: 4];
          alu_op1_d  = req_op1[32*int'(win_id) +: 32];
          alu_op2_d  = req_op2[32*int'(win_id) +: 32];
          rsp_id_d   = win_id;
          rr_ptr_d   = (int'(win_id) == NUM_REQ-1) ? '0 : win_id + 1'b1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        rsp_res_d   = alu_result;
        rsp_ovf_d   = alu_overflow;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready_pad[rsp_id_q]) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      alu_ctrl_q  <= '0;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_res_q   <= '0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_op1_q   <= alu_op1_d;
      alu_op2_q   <= alu_op2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_res_q   <= rsp_res_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  assign alu_ctrl     = alu_ctrl_q;
  assign alu_op1      = alu_op1_q;
  assign alu_op2      = alu_op2_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_res_q;
  assign rsp_overflow = rsp_ovf_q;
  assign busy         = (state_q != IDLE);

`ifdef ALU_ARB_OVF_STAT_EN
  logic       ovf_sticky_q, ovf_sticky_d;
  logic [7:0] ovf_count_q, ovf_count_d;
  logic       ovf_evt;

  assign ovf_evt = (state_q == EXEC) && alu_overflow;

  // Clear has priority over a coincident overflow event.
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    ovf_count_d  = ovf_count_q;
    if (ovf_clr) begin
      ovf_sticky_d = 1'b0;
      ovf_count_d  = '0;
    end else if (ovf_evt) begin
      ovf_sticky_d = 1'b1;
      if (ovf_count_q != 8'hFF) ovf_count_d = ovf_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky_q <= 1'b0;
      ovf_count_q  <= '0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;
  assign ovf_count  = ovf_count_q;
`endif
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single 32-bit ALU between NUM_REQ requesters, for example the execute stage, the address-generation unit and the debug port.
- Accepts one operation at a time over a valid/ready handshake.
- Drives the ALU's ctrl, op1 and op2 inputs from registers.
- Captures result and overflow, then returns them with the winning requester's ID over a second valid/ready handshake.
- Sits between the requesters and the combinational ALU instance.

Parameters:
NUM_REQ, 2, number of requesters (legal range 1..4)
ID_W, 2, width of the requester ID (must satisfy 2**ID_W >= NUM_REQ)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset; one clock; asynchronous assertion
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester grant; one-hot or zero
req_ctrl  input  4*NUM_REQ  flattened ALU opcodes; slice i = [4*i+3:4*i]
req_op1  input  32*NUM_REQ  flattened operand 1; slice i = [32*i+31:32*i]
req_op2  input  32*NUM_REQ  flattened operand 2
alu_ctrl  output  4  registered opcode to the ALU
alu_op1  output  32  registered operand 1 to the ALU
alu_op2  output  32  registered operand 2 to the ALU
alu_result  input  32  ALU combinational result
alu_overflow  input  1  ALU combinational overflow
rsp_valid  output  1  response valid
rsp_ready  input  NUM_REQ  per-requester response ready
rsp_id  output  ID_W  requester that owns the response
rsp_result  output  32  captured result
rsp_overflow  output  1  captured overflow
busy  output  1  high whenever state != IDLE

Behaviour:
- States: IDLE, EXEC, RESP.
- Reset values: state=IDLE, rr_ptr=0, alu_ctrl/op1/op2=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_overflow=0, busy=0.
- IDLE:
  - req_ready[i] is asserted combinationally only for the round-robin winner among req_valid, searching from rr_ptr upward with wrap-around.
  - All other req_ready bits are 0.
  - On handshake with winner w: latch req_ctrl/op1/op2 slice w into alu_* registers, latch w into rsp_id, set rr_ptr=(w+1) mod NUM_REQ, go to EXEC.
  - With no requests, stay in IDLE; rr_ptr is unchanged.
- EXEC (exactly 1 cycle):
  - Sample alu_result and alu_overflow into rsp_result and rsp_overflow.
  - Set rsp_valid=1 and go to RESP.
- RESP:
  - Hold rsp_* stable until rsp_ready[rsp_id]=1.
  - rsp_ready bits of other requesters are ignored.
  - On handshake, rsp_valid=0 next cycle and go to IDLE.
  - req_ready=0 throughout EXEC and RESP.
- Latency and throughput: rsp_valid rises 2 cycles after the request handshake. Minimum issue interval is 3 cycles; there is no overlap.
- alu_* outputs hold the last operation after completion; they are not cleared.
- Opcodes 9..15 are passed through unchanged; the ALU returns 0 with no overflow.
- A requester that drops req_valid before it is granted loses nothing; arbitration is re-evaluated every IDLE cycle.
- NUM_REQ=1: rr_ptr stays 0 and the arbiter degenerates to a pass-through sequencer.
- Reset mid-operation: immediate return to reset values; any in-flight operation is discarded with no response.

Optional Feature:
ALU_ARB_OVF_STAT_EN
- When defined, adds these ports:
  - ovf_clr input 1
  - ovf_sticky output 1
  - ovf_count output 8
- ovf_sticky sets on any EXEC cycle with alu_overflow=1 and stays set until ovf_clr=1.
- ovf_count increments on the same event and saturates at 255.
- If ovf_clr and an overflow event occur in the same cycle, clear wins; the result is sticky=0, count=0.
- Reset value of both outputs is 0.
- When undefined, the ports and logic are absent.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode constants ALU_ADD=0, ALU_SUB=1, ALU_ADDU=2, ALU_SUBU=3, ALU_AND=4, ALU_OR=5, ALU_SLL=6, ALU_SRL=7, ALU_SLT=8.
  - The 2-bit arbiter state encoding: IDLE=0, EXEC=1, RESP=2.
- One sub-module, rr_arbiter: purely combinational.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant and encoded winner ID.
  - Reused by other shared-resource arbiters.

Test Plan:
- Req0 ADD op1=0x7FFFFFFF op2=0x00000001 -> rsp_valid 2 cycles after grant, rsp_id=0, rsp_result=0x80000000, rsp_overflow=1.
- Req0 and req1 both held valid with SUBU 5-3 and SLT 0xFFFFFFFF<1 -> grants alternate 0,1,0,1. Responses are 0x00000002/ovf 0 and 0x00000001/ovf 0.
- rsp_ready held low 5 cycles in RESP -> rsp_result/rsp_id stable, req_ready all 0, busy=1. Handshake on cycle 6 -> IDLE next cycle.
- rsp_ready asserted only by the non-owning requester -> no completion; response stays pending.
- rst_n pulsed low during EXEC of SLL 1<<4 -> no response; all outputs at reset values; next grant goes to requester 0 first.
- With ALU_ARB_OVF_STAT_EN defined: 3 overflowing ADDs -> ovf_count=3, ovf_sticky=1. Then ovf_clr with a 4th overflow in the same cycle -> count=0, sticky=0.
